// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM-stage core, the external loader/debug port and the data memory.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9
);
  // core side
  logic                  core_rd;
  logic                  core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_func3;
  logic [DATA_W-1:0]     core_rdata;
  logic                  core_stall;
  // external requester side
  logic                  ext_req;
  logic                  ext_we;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [2:0]            ext_func3;
  logic                  ext_gnt;
  logic [DATA_W-1:0]     ext_rdata;
  logic                  ext_rvalid;
  // memory side
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;
  // status
  logic [3:0]            wait_cnt;

  // arbiter view
  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, core_func3,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_func3,
    input  mem_rdata,
    output core_rdata, core_stall,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    output wait_cnt
  );

  // environment view (requesters and memory)
  modport master (
    output core_rd, core_wr, core_addr, core_wdata, core_func3,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_func3,
    output mem_rdata,
    input  core_rdata, core_stall,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    input  wait_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the core has priority, an external requester
// is force-granted after MAX_WAIT consecutive denied cycles.
module dmem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic core_req_c;
  logic starved_c;
  logic ext_gnt_c;
  logic ext_rd_c;

  // Grant decision; reset suppresses any external grant.
  always_comb begin
    core_req_c = bus.core_rd | bus.core_wr;
    starved_c  = (wait_cnt_q == CNT_W'(MAX_WAIT));
    ext_gnt_c  = !reset & bus.ext_req & (!core_req_c | starved_c);
    ext_rd_c   = ext_gnt_c & !bus.ext_we;
  end

  // Memory port mux; a core rd+wr collision is treated as a write.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = bus.core_addr;
    bus.mem_wdata = bus.core_wdata;
    bus.mem_func3 = bus.core_func3;
    if (ext_gnt_c) begin
      bus.mem_rd    = !bus.ext_we;
      bus.mem_wr    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
      bus.mem_func3 = bus.ext_func3;
    end else begin
      bus.mem_rd = bus.core_rd & !bus.core_wr;
      bus.mem_wr = bus.core_wr;
    end
  end

  // Requester-facing outputs; only core_rdata sees mem_rdata combinationally.
  always_comb begin
    bus.ext_gnt    = ext_gnt_c;
    bus.core_stall = core_req_c & ext_gnt_c;
    bus.core_rdata = bus.mem_rdata;
    bus.ext_rdata  = ext_rdata_q;
    bus.ext_rvalid = ext_rvalid_q;
    bus.wait_cnt   = wait_cnt_q;
  end

  // Next-state: starvation counter and external read capture.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    ext_rvalid_d = ext_rd_c;
    ext_rdata_d  = ext_rdata_q;
    if (ext_gnt_c || !bus.ext_req) begin
      wait_cnt_d = '0;
    end else if (!starved_c) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    if (ext_rd_c) begin
      ext_rdata_d = bus.mem_rdata;
    end
  end

  // State registers with synchronous reset; flags core rd+wr collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
      assert (!(bus.core_rd && bus.core_wr))
        else $error("dmem_arbiter: core_rd and core_wr asserted together");
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory.
module tb_dmem_arbiter;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DM_ADDRESS = 9;
  localparam int unsigned MAX_WAIT   = 4;

  logic clk;
  logic reset;
  logic load_en;
  int   passed;
  int   total;

  logic [DATA_W-1:0] mem [2**DM_ADDRESS];

  dmem_arbiter_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) bus ();

  dmem_arbiter #(
    .DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data valid in the same cycle, writes on the clock edge.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (load_en) mem[16] <= 32'hCAFE_0010;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    load_en = 1'b1;
    bus.core_rd = 1'b0;  bus.core_wr = 1'b0;
    bus.core_addr = '0;  bus.core_wdata = '0; bus.core_func3 = 3'd2;
    bus.ext_req = 1'b0;  bus.ext_we = 1'b0;
    bus.ext_addr = '0;   bus.ext_wdata = '0;  bus.ext_func3 = 3'd2;

    // reset state, and no external grant while reset is high
    step(); step();
    load_en = 1'b0;
    bus.ext_req = 1'b1;
    #1;
    chk("rst_gnt", 32'(bus.ext_gnt), 32'd0);
    chk("rst_memrd", 32'(bus.mem_rd), 32'd0);
    step();
    chk("rst_wait", 32'(bus.wait_cnt), 32'd0);
    chk("rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("rst_rdata", bus.ext_rdata, 32'd0);
    bus.ext_req = 1'b0;
    reset = 1'b0;
    step();

    // idle core, external read of 0x010
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 9'h010;
    #1;
    chk("rd_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("rd_memrd", 32'(bus.mem_rd), 32'd1);
    chk("rd_addr", 32'(bus.mem_addr), 32'h010);
    chk("rd_stall", 32'(bus.core_stall), 32'd0);
    step();
    bus.ext_req = 1'b0;
    chk("rd_rvalid", 32'(bus.ext_rvalid), 32'd1);
    chk("rd_rdata", bus.ext_rdata, 32'hCAFE_0010);
    step();
    chk("rd_rvalid_pulse", 32'(bus.ext_rvalid), 32'd0);
    chk("rd_rdata_hold", bus.ext_rdata, 32'hCAFE_0010);

    // external write 0x12345678 to 0x040, then core reads it back
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 9'h040;
    bus.ext_wdata = 32'h1234_5678;
    #1;
    chk("wr_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("wr_memwr", 32'(bus.mem_wr), 32'd1);
    chk("wr_memrd", 32'(bus.mem_rd), 32'd0);
    step();
    bus.ext_req = 1'b0; bus.ext_we = 1'b0;
    chk("wr_no_rvalid", 32'(bus.ext_rvalid), 32'd0);
    bus.core_rd = 1'b1; bus.core_addr = 9'h040;
    #1;
    chk("wr_core_rdata", bus.core_rdata, 32'h1234_5678);
    chk("wr_core_gnt", 32'(bus.ext_gnt), 32'd0);
    chk("wr_core_memwr", 32'(bus.mem_wr), 32'd0);
    step();

    // core write collides with external read of 0x020, then forced grant
    bus.core_rd = 1'b0; bus.core_wr = 1'b1;
    bus.core_addr = 9'h020; bus.core_wdata = 32'hDEAD_BEEF;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 9'h020;
    #1;
    chk("col_wait0", 32'(bus.wait_cnt), 32'd0);
    chk("col_gnt", 32'(bus.ext_gnt), 32'd0);
    chk("col_memwr", 32'(bus.mem_wr), 32'd1);
    chk("col_stall", 32'(bus.core_stall), 32'd0);
    step();
    bus.core_wr = 1'b0; bus.core_rd = 1'b1; bus.core_addr = 9'h000;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk("starve_wait", 32'(bus.wait_cnt), 32'(k));
      chk("starve_gnt", 32'(bus.ext_gnt), 32'd0);
      step();
    end
    chk("force_wait", 32'(bus.wait_cnt), 32'd4);
    chk("force_gnt", 32'(bus.ext_gnt), 32'd1);
    chk("force_stall", 32'(bus.core_stall), 32'd1);
    chk("force_addr", 32'(bus.mem_addr), 32'h020);
    step();
    chk("force_rvalid", 32'(bus.ext_rvalid), 32'd1);
    chk("force_rdata", bus.ext_rdata, 32'hDEAD_BEEF);
    chk("after_force_wait", 32'(bus.wait_cnt), 32'd0);
    chk("after_force_gnt", 32'(bus.ext_gnt), 32'd0);
    chk("after_force_stall", 32'(bus.core_stall), 32'd0);
    chk("after_force_addr", 32'(bus.mem_addr), 32'h000);
    bus.ext_req = 1'b0;
    step();

    // request dropped at wait_cnt=3 restarts the count
    bus.ext_req = 1'b1;
    step(); step(); step();
    chk("drop_wait3", 32'(bus.wait_cnt), 32'd3);
    bus.ext_req = 1'b0;
    #1;
    chk("drop_gnt", 32'(bus.ext_gnt), 32'd0);
    step();
    chk("drop_cleared", 32'(bus.wait_cnt), 32'd0);
    bus.ext_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("restart_wait", 32'(bus.wait_cnt), 32'(k));
      chk("restart_gnt", 32'(bus.ext_gnt), 32'd0);
      step();
    end
    chk("restart_force_gnt", 32'(bus.ext_gnt), 32'd1);
    step();
    bus.ext_req = 1'b0; bus.core_rd = 1'b0;
    step();

    // back-to-back external reads
    bus.ext_req = 1'b1; bus.ext_addr = 9'h010;
    step();
    bus.ext_addr = 9'h040;
    chk("b2b_rvalid0", 32'(bus.ext_rvalid), 32'd1);
    chk("b2b_rdata0", bus.ext_rdata, 32'hCAFE_0010);
    step();
    bus.ext_addr = 9'h010;
    chk("b2b_rvalid1", 32'(bus.ext_rvalid), 32'd1);
    chk("b2b_rdata1", bus.ext_rdata, 32'h1234_5678);
    step();
    bus.ext_req = 1'b0;

    // reset in the cycle after a read grant discards the pulse
    chk("rstrd_rvalid_pre", 32'(bus.ext_rvalid), 32'd1);
    reset = 1'b1;
    step();
    chk("rstrd_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("rstrd_rdata", bus.ext_rdata, 32'd0);
    chk("rstrd_wait", 32'(bus.wait_cnt), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("post_rst_gnt", 32'(bus.ext_gnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
